gc_dram_refresh_ctrl: RTL

Initiator-side controller for the 128x64 gain-cell DRAM macro. Arbitrates single host read/write requests against a periodic round-robin refresh engine. Each refresh reads a row and writes it back, so every row is rewritten well inside the 5000-cycle data-retention time. Sits between the system bus and the memory array; it is the only block that drives the array's `re`/`we`/address/data pins.

---
 rtl/gc_dram_refresh_ctrl_if.sv | 32 +++
 rtl/gc_dram_refresh_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/gc_dram_refresh_ctrl_if.sv
// Signal bundle between the host bus, the refresh controller and the gain-cell DRAM array.
// The controller uses the master view; the host and array side uses the slave view.
interface gc_dram_refresh_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64
);
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_rd;

  modport master (
    input  host_valid, host_we, host_addr, host_wdata, mem_rd,
    output host_ready, host_rdata, host_rvalid,
    output mem_re, mem_we, mem_raddr, mem_waddr, mem_in
  );

  modport slave (
    output host_valid, host_we, host_addr, host_wdata, mem_rd,
    input  host_ready, host_rdata, host_rvalid,
    input  mem_re, mem_we, mem_raddr, mem_waddr, mem_in
  );
endinterface

// File: rtl/gc_dram_refresh_ctrl.sv
// Gain-cell DRAM controller: arbitrates single host reads/writes against a round-robin
// read-then-writeback refresh engine, refresh always taking priority.
module gc_dram_refresh_ctrl #(
  parameter int ROWS             = 128,
  parameter int ADDR_W           = 7,
  parameter int DATA_W           = 64,
  parameter int REFRESH_INTERVAL = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  gc_dram_refresh_ctrl_if.master bus,
  output logic [ADDR_W-1:0]     o_ref_row,
  output logic                  o_ref_overdue
);

  localparam int TIMER_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_INTERVAL - 1);
  localparam logic [ADDR_W-1:0]  ROW_LAST   = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, HOST_RD, HOST_WR, REF_RD, REF_WB} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TIMER_W-1:0]  r_timer;
  logic                w_timer_exp;
  logic                r_ref_pending;
  logic                r_ref_overdue;
  logic [ADDR_W-1:0]   r_ref_row;
  logic [ADDR_W-1:0]   r_mem_raddr;
  logic [ADDR_W-1:0]   r_mem_waddr;
  logic [DATA_W-1:0]   r_mem_in;
  logic [DATA_W-1:0]   r_host_rdata;
  logic                r_host_rvalid;
  logic                w_host_ready;
  logic                w_mem_re;
  logic                w_mem_we;
  logic                w_accept;

  assign w_timer_exp = (r_timer == TIMER_LAST);
  assign w_accept    = w_host_ready && bus.host_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_ref_pending)       w_next = REF_RD;
        else if (bus.host_valid) w_next = bus.host_we ? HOST_WR : HOST_RD;
      end
      HOST_RD: w_next = IDLE;
      HOST_WR: w_next = IDLE;
      REF_RD:  w_next = REF_WB;
      REF_WB:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_host_ready = 1'b0;
    w_mem_re     = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      IDLE:    w_host_ready = !r_ref_pending;
      HOST_RD: w_mem_re     = 1'b1;
      REF_RD:  w_mem_re     = 1'b1;
      HOST_WR: w_mem_we     = 1'b1;
      REF_WB:  w_mem_we     = 1'b1;
      default: w_host_ready = 1'b0;
    endcase
  end

  // A timer expiry on the writeback edge re-arms pending instead of letting it clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer       <= '0;
      r_ref_pending <= 1'b0;
      r_ref_overdue <= 1'b0;
      r_ref_row     <= '0;
    end else begin
      r_timer <= w_timer_exp ? '0 : r_timer + 1'b1;
      if (w_timer_exp) begin
        r_ref_pending <= 1'b1;
        if (r_ref_pending) r_ref_overdue <= 1'b1;
      end else if (r_state == REF_WB) begin
        r_ref_pending <= 1'b0;
      end
      if (r_state == REF_WB)
        r_ref_row <= (r_ref_row == ROW_LAST) ? '0 : r_ref_row + 1'b1;
    end
  end

  // Array pins are loaded on the edge entering their active state, so the mem_in
  // register doubles as the refresh buffer and the host request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_raddr   <= '0;
      r_mem_waddr   <= '0;
      r_mem_in      <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (bus.host_we) begin
          r_mem_waddr <= bus.host_addr;
          r_mem_in    <= bus.host_wdata;
        end else begin
          r_mem_raddr <= bus.host_addr;
        end
      end else if (r_state == IDLE && r_ref_pending) begin
        r_mem_raddr <= r_ref_row;
      end else if (r_state == REF_RD) begin
        r_mem_waddr <= r_ref_row;
        r_mem_in    <= bus.mem_rd;
      end
      if (r_state == HOST_RD) r_host_rdata <= bus.mem_rd;
      r_host_rvalid <= (r_state == HOST_RD);
    end
  end

  assign bus.host_ready  = w_host_ready;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.mem_re      = w_mem_re;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_raddr   = r_mem_raddr;
  assign bus.mem_waddr   = r_mem_waddr;
  assign bus.mem_in      = r_mem_in;
  assign o_ref_row       = r_ref_row;
  assign o_ref_overdue   = r_ref_overdue;

endmodule
